serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage directly upstream of the bit-serial pattern detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a registered serial output.
- Double-buffered with a shift register plus one holding register, so consecutive words stream with no idle cycle between frames.

Parameters:
- WIDTH, 4, word width in bits (>=2). Frame length is WIDTH bits, or WIDTH+1 with parity.
- IDLE_BIT, 0, level driven on o while no frame is active.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- din  input  WIDTH  parallel word, sampled on accept
- din_valid  input  1  producer has a word
- din_ready  output  1  feeder can take a word; combinational = !rst && !hold_full
- o  output  1  serial bit, registered, MSB-first
- o_valid  output  1  o carries a frame bit this cycle
- frame_done  output  1  high during the cycle the final bit of a frame is on o
- busy  output  1  state != ST_IDLE || hold_full

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: o=IDLE_BIT, o_valid=0, frame_done=0, busy=0, hold_full=0, bit_cnt=0, state=ST_IDLE. din_ready=0 while rst=1.
- Accept occurs at an edge where din_valid && din_ready. din is ignored otherwise.
- State ST_IDLE:
  - On accept, load din into the shifter, set o=din[WIDTH-1] and o_valid=1, set bit_cnt=0, go to ST_SHIFT.
  - Latency: the first bit is visible in the cycle immediately after the accept edge.
- State ST_SHIFT:
  - Each edge shifts left; o takes the next bit and bit_cnt increments.
  - An accept during ST_SHIFT writes the holding register and sets hold_full.
- Frame end (edge at which bit_cnt==LAST, LAST=WIDTH-1):
  - If hold_full: load the shifter from hold, clear hold_full, stay in ST_SHIFT with a gapless first bit.
  - Else if an accept occurs at this edge (hold is empty, so ready=1): bypass din straight into the shifter, with no gap.
  - Else: o=IDLE_BIT, o_valid=0, go to ST_IDLE.
- frame_done is registered and asserted exactly for the cycle in which bit_cnt==LAST is on o.
- Backpressure: with hold full, din_ready=0 until the frame-end edge that drains hold. The freed slot is available in the following cycle.
- bit_cnt width is clog2(WIDTH+1). It wraps to 0 at each frame load and never exceeds LAST.
- Reset mid-frame: the shifter and hold contents are discarded, outputs return to reset values on that edge, and no partial frame is resumed.
- din must be held stable only on the accept edge. There is no combinational path from din to o.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- When defined: after the WIDTH data bits, one extra bit is appended equal to the even parity (XOR) of the word.
  - LAST=WIDTH.
  - frame_done marks the parity bit.
  - Hold and bypass loads happen at the parity-bit edge.
- When undefined: frames are exactly WIDTH data bits, with no parity logic or storage.

Decomposition:
- Package serial_feeder_pkg holds:
  - state enum {ST_IDLE, ST_SHIFT}
  - function cnt_w(width) returning the counter width
  - constant FRAME_EXTRA (0/1), selected by SERIAL_PARITY_EN
- One sub-module, feeder_hold_buf, is natural: the single-entry holding register with its full flag and write/drain controls.
- The FSM, shifter and counter stay in serial_bit_feeder.

Test Plan:
- Reset then single word: WIDTH=4, din=4'b1101 accepted at edge 1 -> o=1,1,0,1 on cycles 2-5 with o_valid=1; frame_done only in cycle 5; o=0, o_valid=0, busy=0 from cycle 6.
- Back-to-back words: 4'b1101 then 4'b0110 with din_valid held -> o=1,1,0,1,0,1,1,0 with o_valid continuous, two frame_done pulses 4 cycles apart.
- Backpressure: three words presented continuously -> din_ready drops after the second accept and returns 1 the cycle after the first frame ends; all 12 bits are emitted in order.
- Bypass at frame end: hold empty, din=4'b1011 presented only in the last-bit cycle of the prior frame -> the next cycle's o=1 with no o_valid gap.
- Reset mid-frame: assert rst after 2 bits of 4'b1101 -> next cycle o=IDLE_BIT, o_valid=0, din_ready=0, hold cleared; after rst falls, a new word 4'b0011 emits 0,0,1,1 cleanly.
- SERIAL_PARITY_EN defined: din=4'b1101 -> o=1,1,0,1,1 with frame_done on the 5th bit; din=4'b1001 -> parity bit 0.

Source files
------------

// File: rtl/serial_feeder_pkg.sv
// Shared types and constants for the serial bit feeder.
// Optional feature macro: SERIAL_PARITY_EN (appends an even-parity bit to each frame).
package serial_feeder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter width able to hold any bit index of a frame, including the parity slot.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

`ifdef SERIAL_PARITY_EN
    localparam int FRAME_EXTRA = 1;
`else
    localparam int FRAME_EXTRA = 0;
`endif

endpackage

// File: rtl/feeder_hold_buf.sv
// Single-entry holding register that parks the next word while the shifter is busy.
// The write and drain strobes are never asserted together by the parent FSM.
module feeder_hold_buf #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_drain,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Capture a word on write; release the slot when the shifter takes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_wr) begin
            r_full <= 1'b1;
            r_data <= i_wdata;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words over valid/ready and emits them
// MSB-first on a registered output, gapless across frames thanks to a holding register.
// Optional feature macro: SERIAL_PARITY_EN (one even-parity bit after the data bits).
//
// Handshake: a word is taken at a rising edge where din_valid && din_ready. din_ready
// depends only on rst and the holding-register flag, never on din_valid; din need only
// be stable at that edge.
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int   WIDTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             o,
    output logic             o_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int             FL   = WIDTH + FRAME_EXTRA;
    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(FL - 1);

    state_t          r_state, w_state_nxt;
    logic [FL-1:0]   r_shift, w_shift_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic            r_o,     w_o_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_done,  w_done_nxt;

    logic             w_accept;
    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_wr;
    logic             w_hold_drain;
    logic             w_load;
    logic [FL-1:0]    w_load_frame;
    logic [CW-1:0]    w_cnt_inc;

    // Expand a data word into the bit sequence placed on o (parity appended when enabled).
    function automatic logic [FL-1:0] make_frame(input logic [WIDTH-1:0] w);
`ifdef SERIAL_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    assign din_ready = !rst && !w_hold_full;
    assign w_accept  = din_valid && din_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    feeder_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_wr    (w_hold_wr),
        .i_wdata (din),
        .i_drain (w_hold_drain),
        .o_full  (w_hold_full),
        .o_data  (w_hold_data)
    );

    // Next-state logic: load a new frame, shift the current one, or fall back to idle.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_o_nxt      = r_o;
        w_valid_nxt  = r_valid;
        w_done_nxt   = 1'b0;
        w_hold_wr    = 1'b0;
        w_hold_drain = 1'b0;
        w_load       = 1'b0;
        w_load_frame = make_frame(din);

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == LAST) begin
                    // Frame end: held word has priority, then a same-edge bypass, else idle.
                    if (w_hold_full) begin
                        w_hold_drain = 1'b1;
                        w_load       = 1'b1;
                        w_load_frame = make_frame(w_hold_data);
                    end else if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_o_nxt     = IDLE_BIT;
                        w_valid_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_shift_nxt = {r_shift[FL-2:0], 1'b0};
                    w_o_nxt     = r_shift[FL-1];
                    w_cnt_nxt   = w_cnt_inc;
                    w_done_nxt  = (w_cnt_inc == LAST);
                    w_hold_wr   = w_accept;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt = ST_SHIFT;
            w_o_nxt     = w_load_frame[FL-1];
            w_shift_nxt = {w_load_frame[FL-2:0], 1'b0};
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_done_nxt  = 1'b0;
        end
    end

    // State, shifter, counter and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_o     <= IDLE_BIT;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_o     <= w_o_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o          = r_o;
    assign o_valid    = r_valid;
    assign frame_done = r_done;
    assign busy       = (r_state != ST_IDLE) || w_hold_full;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: directed scenarios followed by random traffic, all
// checked against a bit-queue model of the serial stream.
module tb_serial_bit_feeder;

    localparam int   WIDTH    = 4;
    localparam logic IDLE_BIT = 1'b0;
`ifdef SERIAL_PARITY_EN
    localparam int   FL       = WIDTH + 1;
`else
    localparam int   FL       = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             o;
    logic             o_valid;
    logic             frame_done;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected stream: each entry is {last_bit_of_frame, bit}, front = bit on o now.
    logic [1:0]  exp_q[$];
    logic [31:0] obs_bits;
    bit          chk_en;

    serial_bit_feeder #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .o          (o),
        .o_valid    (o_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Append one word's bit sequence (MSB first, optional parity) to the model.
    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            exp_q.push_back({(FL == WIDTH) && (i == 0), w[i]});
        end
        if (FL > WIDTH) begin
            exp_q.push_back({1'b1, ^w});
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d, output bit acc);
        bit m_ready;
        @(negedge clk);
        rst       = r;
        din_valid = v;
        din       = d;
        #1;
        // The feeder holds at most the current frame plus one parked word.
        m_ready = !r && (exp_q.size() <= FL);
        if (chk_en) begin
            check_eq("din_ready", din_ready, m_ready);
            check_eq("o_valid", o_valid, exp_q.size() > 0);
            check_eq("busy", busy, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check_eq("o", o, exp_q[0][0]);
                check_eq("frame_done", frame_done, exp_q[0][1]);
            end else begin
                check_eq("o_idle", o, IDLE_BIT);
                check_eq("frame_done_idle", frame_done, 1'b0);
            end
        end
        if (o_valid === 1'b1) obs_bits = {obs_bits[30:0], o};
        acc = v && m_ready;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) push_word(d);
        end
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, acc);
    endtask

    // Present words back to back, each held until taken.
    task automatic feed_words(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                              input logic [WIDTH-1:0] w2, input int n);
        logic [WIDTH-1:0] words[3];
        int idx;
        int guard;
        bit acc;
        words[0] = w0; words[1] = w1; words[2] = w2;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 100) begin
            cycle(1'b0, 1'b1, words[idx], acc);
            if (acc) idx++;
            guard++;
        end
        check_eq("feed_all_accepted", idx, n);
    endtask

    initial begin
        bit acc;
        logic [31:0] exp_bits;
        rst = 1'b1; din_valid = 1'b0; din = '0;
        chk_en = 1'b0;
        obs_bits = '0;
        cycle(1'b1, 1'b0, '0, acc);
        chk_en = 1'b1;
        cycle(1'b1, 1'b0, '0, acc);   // reset values with rst still high

        // Single word
        obs_bits = '0;
        cycle(1'b0, 1'b1, 4'b1101, acc);
        idle_cycles(FL + 2);
`ifdef SERIAL_PARITY_EN
        exp_bits = 32'b11011;
`else
        exp_bits = 32'b1101;
`endif
        check_eq("single_word_bits", obs_bits, exp_bits);

        // Back-to-back words
        obs_bits = '0;
        feed_words(4'b1101, 4'b0110, 4'b0000, 2);
        idle_cycles(2 * FL + 2);
`ifdef SERIAL_PARITY_EN
        exp_bits = 32'b1101101100;
`else
        exp_bits = 32'b11010110;
`endif
        check_eq("b2b_bits", obs_bits, exp_bits);

        // Backpressure with three words
        feed_words(4'b1010, 4'b0111, 4'b1001, 3);
        idle_cycles(3 * FL + 2);

        // Bypass at frame end: second word appears only in the last-bit cycle
        cycle(1'b0, 1'b1, 4'b1101, acc);
        idle_cycles(FL - 1);
        cycle(1'b0, 1'b1, 4'b1011, acc);
        check_eq("bypass_accept", acc, 1'b1);
        idle_cycles(FL + 2);

        // Reset mid-frame, then a clean new word
        cycle(1'b0, 1'b1, 4'b1101, acc);
        idle_cycles(2);
        cycle(1'b1, 1'b0, '0, acc);
        idle_cycles(1);
        obs_bits = '0;
        cycle(1'b0, 1'b1, 4'b0011, acc);
        idle_cycles(FL + 2);
`ifdef SERIAL_PARITY_EN
        exp_bits = 32'b00110;
`else
        exp_bits = 32'b0011;
`endif
        check_eq("after_reset_bits", obs_bits, exp_bits);

        // Parity-zero word
        cycle(1'b0, 1'b1, 4'b1001, acc);
        idle_cycles(FL + 2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  WIDTH'($urandom_range(0, 15)), acc);
        end
        idle_cycles(3 * FL);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
